// File: rtl/pwm_sample_feeder_if.sv
// pwm_sample_feeder_if: valid/ready duty-sample stream into the PWM sample feeder
//   s_data  : sample word, WIDTH bits
//   s_valid : s_data is valid
//   s_ready : receiver can accept; a transfer happens when s_valid && s_ready
//   master drives data/valid, slave (the feeder) drives ready
interface pwm_sample_feeder_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/pwm_sample_feeder.sv
// pwm_sample_feeder: FIFO-buffered duty feed for a PWM DAC, updating duty only on frame boundaries
//   clk, rst       : clock, synchronous active-high reset
//   s              : sample stream (slave side of pwm_sample_feeder_if)
//   duty           : registered duty word to the PWM block
//   frame_strobe   : one-cycle pulse at the start of each sample period
//   fifo_level     : registered FIFO occupancy
//   underrun       : sticky flag, set when an update finds the FIFO empty
//   underrun_clr   : clears underrun (a simultaneous set wins)
//   Optional: define PWM_FEED_SIGNED_IN_EN for two's complement input converted to offset binary
module pwm_sample_feeder #(
    parameter int WIDTH             = 10,
    parameter int DEPTH             = 8,
    parameter int FRAMES_PER_SAMPLE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    pwm_sample_feeder_if.slave         s,
    output logic [WIDTH-1:0]           duty,
    output logic                       frame_strobe,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       underrun,
    input  logic                       underrun_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int DW = FRAMES_PER_SAMPLE > 1 ? $clog2(FRAMES_PER_SAMPLE) : 1;
`ifdef PWM_FEED_SIGNED_IN_EN
    // Inverting the MSB turns two's complement into offset binary; also the mid-scale reset duty
    localparam logic [WIDTH-1:0] FLIP = {1'b1, {(WIDTH-1){1'b0}}};
`else
    localparam logic [WIDTH-1:0] FLIP = '0;
`endif
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;
    logic [WIDTH-1:0] fcnt;
    logic [DW-1:0]    fdiv;
    logic             empty, full, push, pop, u;
    // Extra wrap bit distinguishes full from empty when the index bits match
    assign empty     = wp == rp;
    assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign s.s_ready = !full;
    assign push      = s.s_valid && !full;
    assign u         = &fcnt && fdiv == DW'(FRAMES_PER_SAMPLE-1);
    assign pop       = u && !empty;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp           <= '0;
            rp           <= '0;
            fcnt         <= '0;
            fdiv         <= '0;
            duty         <= FLIP;
            frame_strobe <= 1'b0;
            fifo_level   <= '0;
            underrun     <= 1'b0;
        end else begin
            fcnt         <= fcnt + 1'b1;
            if (&fcnt)
                fdiv <= fdiv == DW'(FRAMES_PER_SAMPLE-1) ? '0 : fdiv + 1'b1;
            if (push)
                wp <= wp + 1'b1;
            if (pop) begin
                rp   <= rp + 1'b1;
                duty <= mem[rp[AW-1:0]];
            end
            fifo_level   <= fifo_level + LW'(push) - LW'(pop);
            frame_strobe <= u;
            underrun     <= (u && empty) || (underrun && !underrun_clr);
        end
    end
    // Storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wp[AW-1:0]] <= s.s_data ^ FLIP;
    end
endmodule

// File: tb/tb_pwm_sample_feeder.sv
// tb_pwm_sample_feeder: randomized scoreboard bench for pwm_sample_feeder
module tb_pwm_sample_feeder;
    localparam int W  = 5;
    localparam int D  = 4;
    localparam int F  = 3;
    localparam int P  = (2**W) * F;
    localparam int LW = $clog2(D+1);
`ifdef PWM_FEED_SIGNED_IN_EN
    localparam int RST_DUTY = 2**(W-1);
`else
    localparam int RST_DUTY = 0;
`endif
    typedef struct {
        logic [W-1:0] v;
        int           stamp;
    } item_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          underrun_clr;
    logic [W-1:0]  duty;
    logic          frame_strobe;
    logic [LW-1:0] fifo_level;
    logic          underrun;
    pwm_sample_feeder_if #(.WIDTH(W)) sif ();

    pwm_sample_feeder #(.WIDTH(W), .DEPTH(D), .FRAMES_PER_SAMPLE(F)) dut (
        .clk(clk), .rst(rst), .s(sif), .duty(duty), .frame_strobe(frame_strobe),
        .fifo_level(fifo_level), .underrun(underrun), .underrun_clr(underrun_clr)
    );

    always #5 clk = ~clk;

    item_t sb[$];
    int    edge_n = 0;
    bit    started = 0, was_rst = 0, was_clr = 0;
    int    tests = 0, fails = 0;
    int    exp_duty = RST_DUTY;
    bit    exp_under = 0;

    function automatic logic [W-1:0] conv(logic [W-1:0] x);
`ifdef PWM_FEED_SIGNED_IN_EN
        int v;
        v = $signed(x);
        return W'(v + 2**(W-1));
`else
        return x;
`endif
    endfunction

    // Edge bookkeeping: edge_n counts edges since the last reset edge
    always @(posedge clk) begin
        started <= 1;
        was_rst <= rst;
        was_clr <= underrun_clr;
        if (rst) begin
            edge_n <= 0;
            sb.delete();
        end else
            edge_n <= edge_n + 1;
    end

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    // Monitor: every P-th edge after reset is a sample update; consume a sample pushed before it
    always @(negedge clk) if (started) begin
        bit    u, av;
        int    lvl;
        item_t it;
        u  = !was_rst && edge_n > 0 && edge_n % P == 0;
        av = sb.size() > 0 && sb[0].stamp < edge_n;
        if (was_rst) begin
            exp_duty  = RST_DUTY;
            exp_under = 0;
        end else begin
            if (u && av) begin
                it       = sb.pop_front();
                exp_duty = it.v;
            end
            if (u && !av)
                exp_under = 1;
            else if (was_clr)
                exp_under = 0;
        end
        lvl = 0;
        foreach (sb[i]) if (sb[i].stamp <= edge_n) lvl++;
        chk("duty", duty, exp_duty);
        chk("underrun", underrun, exp_under);
        chk("frame_strobe", frame_strobe, u);
        chk("fifo_level", fifo_level, lvl);
        chk("s_ready", sif.s_ready, lvl < D);
    end

    // Stimulus: drive on the falling edge; an accepted sample lands on the next rising edge
    task automatic drive(bit v, logic [W-1:0] d, bit clr, bit r);
        @(negedge clk);
        rst          = r;
        sif.s_valid  = v;
        sif.s_data   = d;
        underrun_clr = clr;
        if (v && sif.s_ready && !r)
            sb.push_back('{conv(d), edge_n + 1});
    endtask

    initial begin
        rst = 1; sif.s_valid = 0; sif.s_data = 0; underrun_clr = 0;
        repeat (3) drive(0, 0, 0, 1);
        drive(1, 5'h1F, 0, 0);
        drive(1, 5'h0F, 0, 0);
        drive(1, 5'h07, 0, 0);
        repeat (4 * P) drive(0, 0, 0, 0);
        drive(0, 0, 1, 0);
        repeat (5) drive(0, 0, 0, 0);
        // clear coinciding with an underrunning update: set must win
        drive(0, 0, 1, 0);
        while ((edge_n + 2) % P != 0) drive(0, 0, 0, 0);
        drive(0, 0, 1, 0);
        repeat (5) drive(0, 0, 0, 0);
        // push on the update edge itself into an empty FIFO
        while ((edge_n + 2) % P != 0) drive(0, 0, 0, 0);
        drive(1, 5'h15, 0, 0);
        repeat (P + 5) drive(0, 0, 0, 0);
        // overfill attempt
        repeat (3 * D) drive(1, W'($urandom), 0, 0);
        repeat (2 * P) drive(0, 0, 0, 0);
        repeat (30 * P) drive($urandom_range(0, 39) == 0, W'($urandom), $urandom_range(0, 199) == 0, 0);
        repeat (5 * P) drive($urandom_range(0, 3) == 0, W'($urandom), 0, 0);
        // reset mid-operation with a sample offered on the reset edge
        repeat (3) drive(1, W'($urandom), 0, 0);
        repeat (50) drive(0, 0, 0, 0);
        drive(1, W'($urandom), 0, 1);
        repeat (P + 10) drive(0, 0, 0, 0);
        drive(1, 5'h10, 0, 0);
        drive(1, 5'h00, 0, 0);
        drive(1, 5'h0F, 0, 0);
        repeat (4 * P) drive(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
